sram_word_unpacker: RTL and testbench
=====================================

// Module: sram_word_unpacker
// PURPOSE
//  Read-side counterpart of the 16->SRAM word packer. On start, fetches 32 consecutive 16-bit
//  words from SRAM and unpacks each into two bytes of a 64-byte (8x8) buffer.
//  Then streams the 64 bytes in row-major (i,j) order to the next pipeline stage over a
//  valid/ready handshake. done pulses after the last byte is accepted.
// PARAMETERS
//  AW  18  SRAM word-address width
//  DW  16  SRAM data width (fixed 16; two bytes per word)
// PORTS
//  clock        in   1   single clock; all logic posedge
//  reset        in   1   synchronous, active-high
//  start        in   1   begin one 32-word fetch + 64-byte stream; sampled only in IDLE
//  base_addr    in   AW  first SRAM word address; captured when start is accepted
//  sram_addr    out  AW  SRAM read address
//  sram_ren     out  1   SRAM read enable; rdata valid exactly 1 cycle later
//  sram_rdata   in   DW  SRAM read data
//  out_data     out  8   current byte
//  out_valid    out  1   out_data/out_icounter/out_jcounter valid
//  out_ready    in   1   consumer accepts byte when out_valid && out_ready
//  out_icounter out  3   row of current byte (0..7)
//  out_jcounter out  3   column of current byte (0..7)
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle pulse after byte 63 is accepted
// BEHAVIOUR
//  Reset: all outputs 0, FSM->IDLE, word/byte counters 0; buffer contents not cleared.
//  FSM: IDLE -(start)-> FETCH -(32 reads issued)-> DRAIN -(1 cycle)-> STREAM -(byte 63 accepted)-> DONE -> IDLE.
//  FETCH: sram_ren=1 every cycle for 32 cycles; sram_addr = base_addr + w, w=0..31, sum mod 2^AW.
//  Capture: rdata arriving cycle after read w writes buf[2w]=rdata[15:8], buf[2w+1]=rdata[7:0].
//  DRAIN: captures word 31; sram_ren=0.
//  Timing: start sampled cycle 0; ren cycles 1..32; captures 2..33; out_valid first high cycle 34.
//  STREAM: byte index k=8*i+j; out_data=buf[k]; index advances only on valid&&ready;
//   outputs held stable while valid&&!ready. j wraps 7->0 with i+1.
//  DONE: one cycle, done=1, out_valid=0, busy=1; next cycle IDLE, busy=0.
//  start outside IDLE ignored (no restart, no base_addr recapture).
//  Reset mid-operation: next cycle sram_ren=0, out_valid=0, IDLE; in-flight rdata discarded.
//  Reset and start together: reset wins.
//  out_ready ignored outside STREAM; never produces more or fewer than 64 bytes.
// CONFIGURATION
//  UNPACK_LE_EN undefined: high byte first (buf[2w]=rdata[15:8]); inverse of packer's {b[2w],b[2w+1]}.
//  UNPACK_LE_EN defined: low byte first (buf[2w]=rdata[7:0], buf[2w+1]=rdata[15:8]).
//  No other timing or interface change.
// STRUCTURE
//  Shared package mem_pkg: FSM state encoding (IDLE,FETCH,DRAIN,STREAM,DONE),
//   NUM_WORDS=32, NUM_BYTES=64, ROW_BITS=3, COL_BITS=3.
//  Sub-module byte_buf64: 64x8 register file; one 2-byte write port (word index, 16-bit data);
//   one combinational byte read port (6-bit index).
//  Top: FSM, 5-bit word counter, 6-bit byte counter, address adder, handshake logic.
// TESTING
//  1 SRAM model word[a]={a[6:0],1'b0,a[6:0],1'b1} low bytes; base=0x100, ready=1
//    -> addr 0x100..0x11F on 32 ren cycles; bytes match model in order; done cycle after byte 63.
//  2 Backpressure: out_ready=0 for 3 cycles at k=10 -> out_data/i/j held (i=1,j=2);
//    stream resumes with k=11; total 64 bytes.
//  3 start pulsed during FETCH and STREAM -> ignored; base_addr unchanged; single done pulse.
//  4 reset at 12th ren cycle -> next cycle ren=0, busy=0; new start with base=0 completes normally.
//  5 Address wrap: AW=18, base=0x3FFF0 -> addrs 0x3FFF0..0x3FFFF then 0x00000..0x0000F.
//  6 UNPACK_LE_EN defined, word0=0x0102 -> bytes 0x02 then 0x01; undefined -> 0x01 then 0x02.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizes for the SRAM word unpacker.
// FSM encoding plus buffer/counter geometry.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_STREAM,
    ST_DONE
  } state_e;

  localparam int NUM_WORDS = 32;
  localparam int NUM_BYTES = 64;
  localparam int ROW_BITS  = 3;
  localparam int COL_BITS  = 3;
  localparam int WORD_BITS = $clog2(NUM_WORDS);
  localparam int BYTE_BITS = ROW_BITS + COL_BITS;

endpackage

// File: rtl/byte_buf64.sv
// 64x8 byte register file: one 2-byte word write port,
// one combinational byte read port. Contents are never cleared.
module byte_buf64
  import mem_pkg::*;
(
  input  logic                 clock,
  input  logic                 we,
  input  logic [WORD_BITS-1:0] widx,
  input  logic [15:0]          wdata,
  input  logic [BYTE_BITS-1:0] ridx,
  output logic [7:0]           rdata
);

  logic [7:0] mem_q [NUM_BYTES];

  // wdata[15:8] always lands at the even byte address
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[{widx, 1'b0}] <= wdata[15:8];
      mem_q[{widx, 1'b1}] <= wdata[7:0];
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/sram_word_unpacker.sv
// Fetches 32 SRAM words, unpacks to 64 bytes, streams them out.
// UNPACK_LE_EN: place the low byte of each word first.
module sram_word_unpacker
  import mem_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  output logic [AW-1:0]       sram_addr,
  output logic                sram_ren,
  input  logic [DW-1:0]       sram_rdata,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROW_BITS-1:0] out_icounter,
  output logic [COL_BITS-1:0] out_jcounter,
  output logic                busy,
  output logic                done
);

  state_e               state_q, state_d;
  logic [WORD_BITS-1:0] wcnt_q, wcnt_d;
  logic [BYTE_BITS-1:0] bcnt_q, bcnt_d;
  logic [AW-1:0]        base_q, base_d;
  logic                 rd_pend_q;
  logic [WORD_BITS-1:0] rd_word_q;
  logic [15:0]          wdata;
  logic [7:0]           buf_byte;

`ifdef UNPACK_LE_EN
  assign wdata = {sram_rdata[7:0], sram_rdata[15:8]};
`else
  assign wdata = sram_rdata[15:0];
`endif

  byte_buf64 u_buf (
    .clock (clock),
    .we    (rd_pend_q),
    .widx  (rd_word_q),
    .wdata (wdata),
    .ridx  (bcnt_q),
    .rdata (buf_byte)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      base_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_word_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bcnt_q    <= bcnt_d;
      base_q    <= base_d;
      // read data returns one cycle after each FETCH cycle
      rd_pend_q <= (state_q == ST_FETCH);
      rd_word_q <= wcnt_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    base_d    = base_q;
    sram_addr = '0;
    sram_ren  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          wcnt_d  = '0;
          base_d  = base_addr;
        end
      end
      ST_FETCH: begin
        sram_ren  = 1'b1;
        sram_addr = base_q + AW'(wcnt_q);
        wcnt_d    = wcnt_q + 1'b1;
        if (wcnt_q == WORD_BITS'(NUM_WORDS - 1))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        bcnt_d  = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BYTE_BITS'(NUM_BYTES - 1))
            state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign out_data     = out_valid ? buf_byte : 8'h00;
  assign out_icounter = out_valid ? bcnt_q[BYTE_BITS-1:COL_BITS] : '0;
  assign out_jcounter = out_valid ? bcnt_q[COL_BITS-1:0] : '0;

endmodule

// File: tb/tb_sram_word_unpacker.sv
// Self-checking bench for sram_word_unpacker against a
// queue-based byte-stream reference model.
module tb_sram_word_unpacker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] base_addr;
  logic [17:0] sram_addr;
  logic        sram_ren;
  logic [15:0] sram_rdata = 16'h0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_icounter;
  logic [2:0]  out_jcounter;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [15:0] salt = 16'h0;
  bit          ovr_en = 1'b0;
  logic [17:0] ovr_addr = 18'h0;
  logic [15:0] ovr_val = 16'h0;
  logic [7:0]  exp_q [$];
  logic [7:0]  obs0, obs1;

  sram_word_unpacker #(.AW(18), .DW(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .sram_addr    (sram_addr),
    .sram_ren     (sram_ren),
    .sram_rdata   (sram_rdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_icounter (out_icounter),
    .out_jcounter (out_jcounter),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] word_of(logic [17:0] a);
    if (ovr_en && a == ovr_addr) return ovr_val;
    return {a[6:0], 1'b0, a[6:0], 1'b1} ^ salt;
  endfunction

  // SRAM model: data valid the cycle after the read enable
  always @(posedge clock)
    sram_rdata <= sram_ren ? word_of(sram_addr) : 16'h0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(logic [17:0] base);
    logic [15:0] wd;
    exp_q.delete();
    for (int w = 0; w < 32; w++) begin
      wd = word_of(base + 18'(w));
`ifdef UNPACK_LE_EN
      exp_q.push_back(wd[7:0]);
      exp_q.push_back(wd[15:8]);
`else
      exp_q.push_back(wd[15:8]);
      exp_q.push_back(wd[7:0]);
`endif
    end
  endtask

  // mode: 0 ready=1, 1 stall 3 cycles at k=10, 2 stray starts, 3 random ready
  task automatic run_op(logic [17:0] base, int mode, int rst_at);
    int cyc, nren, k, first_v, done_cnt, last_acc, bp_cnt;
    bit finished, rdy;
    logic [17:0] ea;
    build_exp(base);
    @(negedge clock);
    base_addr = base;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    base_addr = ~base;
    cyc = 1; nren = 0; k = 0; first_v = -1;
    done_cnt = 0; last_acc = -10; bp_cnt = 0; finished = 1'b0;
    while (!finished && cyc < 600) begin
      if (sram_ren) begin
        ea = base + 18'(nren);
        chk("ren_addr", 32'(sram_addr), 32'(ea));
        chk("ren_cycle", cyc, nren + 1);
        nren++;
        if (rst_at > 0 && nren == rst_at) begin
          reset = 1'b1;
          @(negedge clock);
          reset = 1'b0;
          chk("rst_ren", 32'(sram_ren), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_valid", 32'(out_valid), 0);
          return;
        end
      end
      if (mode == 2) begin
        start = (cyc == 5) || (out_valid && k == 20);
        base_addr = 18'($urandom);
      end
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        rdy = 1'b1;
        if (mode == 1 && k == 10 && bp_cnt < 3) begin
          rdy = 1'b0;
          bp_cnt++;
          chk("bp_i", 32'(out_icounter), 1);
          chk("bp_j", 32'(out_jcounter), 2);
        end
        if (mode == 3) rdy = ($urandom_range(0, 3) != 0);
        out_ready = rdy;
        if (k < 64) begin
          chk("data", 32'(out_data), 32'(exp_q[k]));
          chk("icnt", 32'(out_icounter), k / 8);
          chk("jcnt", 32'(out_jcounter), k % 8);
        end else begin
          chk("extra_byte", k, 63);
        end
        if (rdy) begin
          if (k == 0) obs0 = out_data;
          if (k == 1) obs1 = out_data;
          last_acc = cyc;
          k++;
        end
      end else begin
        out_ready = 1'($urandom);
      end
      if (done) begin
        done_cnt++;
        chk("done_cycle", cyc, last_acc + 1);
        chk("done_k", k, 64);
        chk("done_valid", 32'(out_valid), 0);
        chk("done_busy", 32'(busy), 1);
      end
      if (!busy) finished = 1'b1;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    chk("timeout", 32'(finished), 1);
    chk("nren", nren, 32);
    chk("first_valid", first_v, 34);
    chk("bytes", k, 64);
    chk("done_cnt", done_cnt, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    base_addr = 18'h0;
    repeat (3) @(negedge clock);
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_ren0", 32'(sram_ren), 0);
    chk("rst_addr0", 32'(sram_addr), 0);
    chk("rst_valid0", 32'(out_valid), 0);
    chk("rst_done0", 32'(done), 0);
    chk("rst_data0", 32'(out_data), 0);
    chk("rst_ij0", 32'({out_icounter, out_jcounter}), 0);
    reset = 1'b0;
    @(negedge clock);

    run_op(18'h100, 0, 0);
    salt = 16'($urandom);
    run_op(18'(($urandom % 1000) + 18'h100), 1, 0);
    run_op(18'($urandom), 2, 0);
    run_op(18'($urandom), 0, 12);
    run_op(18'h0, 0, 0);
    run_op(18'h3FFF0, 0, 0);

    salt = 16'h0;
    ovr_en = 1'b1;
    ovr_addr = 18'h200;
    ovr_val = 16'h0102;
    run_op(18'h200, 0, 0);
`ifdef UNPACK_LE_EN
    chk("order_b0", 32'(obs0), 32'h02);
    chk("order_b1", 32'(obs1), 32'h01);
`else
    chk("order_b0", 32'(obs0), 32'h01);
    chk("order_b1", 32'(obs1), 32'h02);
`endif
    ovr_en = 1'b0;

    for (int n = 0; n < 2; n++) begin
      salt = 16'($urandom);
      run_op(18'($urandom), 3, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
